// File: rtl/cache_line_ctrl_if.sv
// Bus bundle between the cache line controller, MEM stage,
// SRAM controller and cache array.
interface cache_line_ctrl_if #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int CACHE_ADDR_W = 19
);
  logic [ADDR_W-1:0]       address;
  logic [DATA_W-1:0]       wdata;
  logic                    mem_r_en;
  logic                    mem_w_en;
  logic [DATA_W-1:0]       rdata;
  logic                    ready;
  logic [DATA_W-1:0]       sram_rdata;
  logic                    sram_ready;
  logic [ADDR_W-1:0]       sram_address;
  logic [DATA_W-1:0]       sram_wdata;
  logic                    sram_w_en;
  logic                    sram_r_en;
  logic                    hit;
  logic [DATA_W-1:0]       cache_rdata;
  logic                    cache_w_en;
  logic [DATA_W-1:0]       cache_wdata;
  logic [CACHE_ADDR_W-1:0] cache_address;
  logic                    change_lru;
  logic                    invalidate;

  modport master (
    input  address, wdata, mem_r_en, mem_w_en,
    input  sram_rdata, sram_ready, hit, cache_rdata,
    output rdata, ready,
    output sram_address, sram_wdata,
    output sram_w_en, sram_r_en,
    output cache_w_en, cache_wdata, cache_address,
    output change_lru, invalidate
  );

  modport slave (
    output address, wdata, mem_r_en, mem_w_en,
    output sram_rdata, sram_ready, hit, cache_rdata,
    input  rdata, ready,
    input  sram_address, sram_wdata,
    input  sram_w_en, sram_r_en,
    input  cache_w_en, cache_wdata, cache_address,
    input  change_lru, invalidate
  );
endinterface

// File: rtl/cache_line_ctrl.sv
// Write-through, no-write-allocate cache line controller with
// critical-word-first wrapping line fill.
module cache_line_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LINE_WORDS   = 2,
  parameter int CACHE_ADDR_W = 19,
  parameter int CACHE_BASE   = 1024,
  parameter int WRITE_UPDATE = 0
) (
  input logic               clk,
  input logic               rst,
  cache_line_ctrl_if.master bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] crit_q, crit_d;
  logic              gap_q, gap_d;

  logic [OFF_W-1:0]  idx;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] cache_off;
  logic              unused_bits;

  // word index wraps inside the line, never carries into line bits
  assign idx = bus.address[2 +: OFF_W] + cnt_q;
  assign line_addr = {bus.address[ADDR_W-1:2+OFF_W], idx, 2'b00};
  assign cache_off = line_addr - ADDR_W'(CACHE_BASE);

  assign bus.sram_address  = line_addr;
  assign bus.cache_address = cache_off[CACHE_ADDR_W-1:0];
  assign bus.sram_wdata    = bus.wdata;

  assign unused_bits = ^{bus.address[1:0],
                         cache_off[ADDR_W-1:CACHE_ADDR_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crit_q  <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crit_q  <= crit_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    crit_d          = crit_q;
    gap_d           = 1'b0;
    bus.rdata       = crit_q;
    bus.ready       = 1'b0;
    bus.sram_r_en   = 1'b0;
    bus.sram_w_en   = 1'b0;
    bus.cache_w_en  = 1'b0;
    bus.cache_wdata = '0;
    bus.change_lru  = 1'b0;
    bus.invalidate  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_r_en) begin
          if (bus.hit) begin
            bus.ready = 1'b1;
            bus.rdata = bus.cache_rdata;
          end else begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end else if (bus.mem_w_en) begin
          state_d = WRITE;
          if (bus.hit) begin
            if (WRITE_UPDATE != 0) begin
              bus.cache_w_en  = 1'b1;
              bus.cache_wdata = bus.wdata;
            end else begin
              bus.invalidate = 1'b1;
            end
          end
        end
      end
      FILL: begin
        bus.sram_r_en = ~gap_q;
        if (bus.sram_ready && !gap_q) begin
          bus.cache_w_en  = 1'b1;
          bus.cache_wdata = bus.sram_rdata;
          gap_d           = 1'b1;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == '0) crit_d = bus.sram_rdata;
          if (cnt_q == LAST) begin
            bus.change_lru = 1'b1;
            state_d        = DONE;
          end
        end
      end
      WRITE: begin
        bus.sram_w_en = 1'b1;
        if (bus.sram_ready) state_d = DONE;
      end
      DONE: begin
        bus.ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Scoreboard bench: DUT A invalidates on write hit, DUT B updates;
// both share stimulus and one SRAM model driven by A's requests.
module tb_cache_line_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 19;
  localparam int LW = 4;

  typedef struct {logic chk; logic [31:0] d;} rd_t;
  typedef struct {logic [18:0] a; logic [31:0] d;} cw_t;
  typedef struct {logic [31:0] a; logic we; logic [31:0] d;} sr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] cache_rdata = '0;
  logic [31:0] sram_rdata = '0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic        hit = 1'b0;
  logic        sram_ready = 1'b0;

  int nchk = 0;
  int nerr = 0;
  rd_t rdq0[$];
  rd_t rdq1[$];
  cw_t cwq0[$];
  cw_t cwq1[$];
  sr_t srq[$];
  int lru_exp[2];
  int inv_exp[2];
  logic beat_rd = 1'b0;
  logic lru_seen = 1'b0;

  cache_line_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CACHE_ADDR_W(CW)) ia ();
  cache_line_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CACHE_ADDR_W(CW)) ib ();

  assign ia.address = address;
  assign ia.wdata = wdata;
  assign ia.mem_r_en = mem_r_en;
  assign ia.mem_w_en = mem_w_en;
  assign ia.sram_rdata = sram_rdata;
  assign ia.sram_ready = sram_ready;
  assign ia.hit = hit;
  assign ia.cache_rdata = cache_rdata;
  assign ib.address = address;
  assign ib.wdata = wdata;
  assign ib.mem_r_en = mem_r_en;
  assign ib.mem_w_en = mem_w_en;
  assign ib.sram_rdata = sram_rdata;
  assign ib.sram_ready = sram_ready;
  assign ib.hit = hit;
  assign ib.cache_rdata = cache_rdata;

  cache_line_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW),
    .CACHE_ADDR_W(CW), .CACHE_BASE(1024), .WRITE_UPDATE(0)
  ) u_a (.clk(clk), .rst(rst), .bus(ia.master));

  cache_line_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW),
    .CACHE_ADDR_W(CW), .CACHE_BASE(1024), .WRITE_UPDATE(1)
  ) u_b (.clk(clk), .rst(rst), .bus(ib.master));

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // SRAM: 2-cycle read latency, 3-cycle write latency
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || sram_ready) begin
        sram_ready = 1'b0;
        cnt = 0;
      end else if (ia.sram_r_en || ia.sram_w_en) begin
        cnt++;
        if (cnt >= (ia.sram_w_en ? 3 : 2)) begin
          sram_ready = 1'b1;
          sram_rdata = 32'hA500_0000 | ia.sram_address;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic mon(input int d, input logic rdy,
                     input logic [31:0] rd, input logic cwe,
                     input logic [18:0] ca, input logic [31:0] cd,
                     input logic lru, input logic inv);
    rd_t r;
    cw_t c;
    string p;
    int qs;
    p = (d == 0) ? "A" : "B";
    if (rdy) begin
      qs = (d == 0) ? rdq0.size() : rdq1.size();
      if (qs == 0) begin
        check($sformatf("%s ready unexpected", p), rdy, 0);
      end else begin
        if (d == 0) r = rdq0.pop_front();
        else r = rdq1.pop_front();
        if (r.chk) check($sformatf("%s rdata", p), rd, r.d);
      end
    end
    if (cwe) begin
      qs = (d == 0) ? cwq0.size() : cwq1.size();
      if (qs == 0) begin
        check($sformatf("%s cache_w_en unexpected", p), cwe, 0);
      end else begin
        if (d == 0) c = cwq0.pop_front();
        else c = cwq1.pop_front();
        check($sformatf("%s cache_address", p), ca, c.a);
        check($sformatf("%s cache_wdata", p), cd, c.d);
      end
    end
    if (lru) begin
      if (lru_exp[d] == 0)
        check($sformatf("%s change_lru unexpected", p), lru, 0);
      else lru_exp[d]--;
    end
    if (inv) begin
      if (inv_exp[d] == 0)
        check($sformatf("%s invalidate unexpected", p), inv, 0);
      else inv_exp[d]--;
    end
    if (lru || inv)
      check($sformatf("%s lru/inv exclusive", p), lru & inv, 0);
  endtask

  always @(negedge clk) begin
    sr_t s;
    if (rst) begin
      mon(0, ia.ready, ia.rdata, ia.cache_w_en, ia.cache_address,
          ia.cache_wdata, ia.change_lru, ia.invalidate);
      mon(1, ib.ready, ib.rdata, ib.cache_w_en, ib.cache_address,
          ib.cache_wdata, ib.change_lru, ib.invalidate);
      if (lru_seen) check("A ready after lru", ia.ready, 1);
      lru_seen = ia.change_lru;
      if (ia.change_lru) check("A lru with beat", sram_ready, 1);
      if (beat_rd) check("A r_en gap", ia.sram_r_en, 0);
      beat_rd = sram_ready & ia.sram_r_en;
      if (sram_ready) begin
        if (srq.size() == 0) begin
          check("A sram beat unexpected", sram_ready, 0);
        end else begin
          s = srq.pop_front();
          check("A sram_address", ia.sram_address, s.a);
          check("A sram_w_en", ia.sram_w_en, s.we);
          if (s.we) check("A sram_wdata", ia.sram_wdata, s.d);
        end
      end
    end else begin
      beat_rd = 1'b0;
      lru_seen = 1'b0;
    end
  end

  task automatic push_beat(input logic [31:0] a, input logic [18:0] ca);
    srq.push_back('{a: a, we: 1'b0, d: 32'h0});
    cwq0.push_back('{a: ca, d: 32'hA500_0000 | a});
    cwq1.push_back('{a: ca, d: 32'hA500_0000 | a});
  endtask

  task automatic push_rd(input logic chk, input logic [31:0] d);
    rdq0.push_back('{chk: chk, d: d});
    rdq1.push_back('{chk: chk, d: d});
  endtask

  task automatic start_req(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic h, input logic [31:0] cr);
    @(posedge clk);
    #1;
    mem_r_en = r;
    mem_w_en = w;
    address = a;
    wdata = wd;
    hit = h;
    cache_rdata = cr;
  endtask

  task automatic end_req();
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    hit = 1'b0;
  endtask

  task automatic wait_ready(input string n, output int wcyc);
    bit got;
    got = 1'b0;
    wcyc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ia.sram_w_en) wcyc++;
      got = ia.ready;
    end
    check({n, " ready"}, got, 1);
  endtask

  logic [31:0] wv_a[3] = '{32'h410, 32'h41C, 32'h800};
  logic [31:0] wv_d[3] = '{32'h1234_5678, 32'h0BAD_F00D, 32'hDEAD_BEEF};
  logic        wv_h[3] = '{1'b1, 1'b1, 1'b0};
  logic [18:0] wv_c[3] = '{19'h10, 19'h1C, 19'h400};

  initial begin
    int wc;
    bit got;
    lru_exp = '{0, 0};
    inv_exp = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", ia.ready, 0);
    check("rst sram_r_en", ia.sram_r_en, 0);
    check("rst sram_w_en", ia.sram_w_en, 0);
    check("rst cache_w_en", ia.cache_w_en, 0);
    check("rst change_lru", ia.change_lru, 0);
    check("rst invalidate", ia.invalidate, 0);
    check("rst B ready", ib.ready, 0);
    rst = 1'b1;

    // read hit
    push_rd(1'b1, 32'hCAFE_0001);
    start_req(1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 32'hCAFE_0001);
    @(negedge clk);
    check("hit same cycle ready", ia.ready, 1);
    check("hit no sram_r_en", ia.sram_r_en, 0);
    end_req();

    // read miss, critical word first with wrap
    push_beat(32'h40C, 19'hC);
    push_beat(32'h400, 19'h0);
    push_beat(32'h404, 19'h4);
    push_beat(32'h408, 19'h8);
    lru_exp[0]++;
    lru_exp[1]++;
    push_rd(1'b1, 32'hA500_040C);
    start_req(1'b1, 1'b0, 32'h40C, 32'h0, 1'b0, 32'h0);
    wait_ready("miss", wc);
    end_req();

    // writes: A invalidates on hit, B updates cache word
    for (int i = 0; i < 3; i++) begin
      srq.push_back('{a: wv_a[i], we: 1'b1, d: wv_d[i]});
      if (wv_h[i]) begin
        inv_exp[0]++;
        cwq1.push_back('{a: wv_c[i], d: wv_d[i]});
      end
      push_rd(1'b0, 32'h0);
      start_req(1'b0, 1'b1, wv_a[i], wv_d[i], wv_h[i], 32'h0);
      wait_ready($sformatf("write%0d", i), wc);
      check($sformatf("write%0d w_en cycles", i), wc, 3);
      end_req();
    end

    // reset during beat 2 of a fill
    push_beat(32'h408, 19'h8);
    start_req(1'b1, 1'b0, 32'h408, 32'h0, 1'b0, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = ia.cache_w_en;
    end
    check("rst-fill beat1", got, 1);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("rst-fill r_en before", ia.sram_r_en, 1);
    rst = 1'b0;
    #1;
    check("rst-fill sram_r_en", ia.sram_r_en, 0);
    check("rst-fill cache_w_en", ia.cache_w_en, 0);
    check("rst-fill change_lru", ia.change_lru, 0);
    check("rst-fill ready", ia.ready, 0);
    check("rst-fill B sram_r_en", ib.sram_r_en, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    push_beat(32'h408, 19'h8);
    push_beat(32'h40C, 19'hC);
    push_beat(32'h400, 19'h0);
    push_beat(32'h404, 19'h4);
    lru_exp[0]++;
    lru_exp[1]++;
    push_rd(1'b1, 32'hA500_0408);
    wait_ready("rst-fill restart", wc);
    end_req();

    // back-to-back: fill, then held request hits next cycle
    push_beat(32'h604, 19'h204);
    push_beat(32'h608, 19'h208);
    push_beat(32'h60C, 19'h20C);
    push_beat(32'h600, 19'h200);
    lru_exp[0]++;
    lru_exp[1]++;
    push_rd(1'b1, 32'hA500_0604);
    push_rd(1'b1, 32'hBEEF_0006);
    start_req(1'b1, 1'b0, 32'h604, 32'h0, 1'b0, 32'h0);
    wait_ready("b2b fill", wc);
    @(posedge clk);
    #1;
    hit = 1'b1;
    cache_rdata = 32'hBEEF_0006;
    @(negedge clk);
    check("b2b hit ready", ia.ready, 1);
    check("b2b no refill", ia.sram_r_en, 0);
    end_req();

    repeat (20) @(posedge clk);
    check("A rd queue drained", rdq0.size(), 0);
    check("B rd queue drained", rdq1.size(), 0);
    check("A cw queue drained", cwq0.size(), 0);
    check("B cw queue drained", cwq1.size(), 0);
    check("sram queue drained", srq.size(), 0);
    check("A lru all seen", lru_exp[0], 0);
    check("B lru all seen", lru_exp[1], 0);
    check("A inv all seen", inv_exp[0], 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
